throw_charge_fsm: RTL and testbench
===================================

# throw_charge_fsm

Parametrised successor to the single-player throw controller in the game logic. It converts the player's space-key press/hold/release into a charged throw: live power build-up while held, minimum-power tap rejection, and a one-cycle launch strobe carrying the latched power. It also drives a multi-frame throw animation index for the sprite renderer. One instance per player; each instance is enabled only while `whose_turn` equals its `LOCAL_PLAYER`. It sits between the keyboard decoder and the projectile/physics and sprite-draw blocks.

## Interface
Parameters:
- `TURN_W`, 1: width of `whose_turn`.
- `LOCAL_PLAYER`, 0: `whose_turn` value that enables this instance.
- `POWER_W`, 7: power width; power saturates at 2^POWER_W-1.
- `MIN_POWER`, 4: release with power below this is a rejected tap.
- `CHARGE_STEP_CYCLES`, 650_000: CHARGE cycles per power increment (10 ms at 65 MHz).
- `HOLD_CYCLES`, 65_000_000: THROW duration in cycles (1 s at 65 MHz).
- `N_FRAMES`, 4: animation frames, ≥3; `IDX_W` = max(1, $clog2(N_FRAMES)).
- `FRAME_CYCLES`, 16_250_000: cycles per throw frame step.

Ports:
- `clk` in 1: system clock, 65 MHz.
- `rst_n` in 1: reset, asynchronous, active-low.
- `space` in 1: key level, already synchronised/debounced upstream.
- `whose_turn` in TURN_W: current player.
- `index` out IDX_W: sprite frame.
- `power` out POWER_W: live power in CHARGE, latched power in THROW/DONE, 0 otherwise.
- `throw_start` out 1: one-cycle launch strobe.
- `throw_enable` out 1: high throughout THROW.
- `busy` out 1: high in CHARGE, THROW, DONE.

## Operation
- States: OFF, ARM, IDLE, CHARGE, THROW, DONE.
- Turn gate: `whose_turn != LOCAL_PLAYER` forces OFF at the next edge from any state. This has priority over every other transition. No `throw_start` is issued. All counters and `power` are cleared.
- OFF → ARM when `whose_turn == LOCAL_PLAYER`.
- ARM → IDLE when `space`=0. A key already held when the turn begins never fires.
- IDLE → CHARGE when `space`=1. `power` and the step counter clear to 0.
- CHARGE, `space`=1:
  - The step counter counts 0..CHARGE_STEP_CYCLES-1.
  - On wrap, `power` increments, saturating at all-ones.
- CHARGE, `space`=0:
  - If `power` ≥ MIN_POWER: go to THROW. `power` latches; frame and hold counters clear.
  - Otherwise: go to IDLE with `power`=0 and no strobe.
- THROW lasts exactly HOLD_CYCLES cycles, then DONE.
- DONE lasts 1 cycle. It goes to IDLE if `space`=0, else to ARM.
- `index`:
  - 0 in OFF, ARM, IDLE; 1 in CHARGE.
  - In THROW: 2 on entry, +1 every FRAME_CYCLES cycles, saturating at N_FRAMES-1.
  - DONE holds the last THROW value.
- Counter widths are $clog2 of their terminal count (minimum 1 bit); no wrap is possible at the defaults.

## Timing
- Reset (asynchronous, immediate, no clock needed): state OFF, `index`=0, `power`=0, `throw_start`=0, `throw_enable`=0, `busy`=0.
- All outputs are registered or decoded from registered state. They are valid in the first cycle of the new state.
- Press sampled at edge N → CHARGE and `index`=1 from cycle N+1.
- After k full CHARGE cycles, `power` = min(floor(k/CHARGE_STEP_CYCLES), 2^POWER_W-1).
- Release sampled at edge R in CHARGE with sufficient power:
  - `throw_start`=1 for exactly cycle R+1.
  - `throw_enable`=1 for cycles R+1..R+HOLD_CYCLES.
  - DONE at R+HOLD_CYCLES+1; IDLE (`index`=0) at R+HOLD_CYCLES+2.
- `power` is stable from `throw_start` through DONE. Consumers sample it with `throw_start`.
- Release and turn change on the same edge: OFF, no strobe.
- Re-press during THROW/DONE is ignored; DONE routes to ARM.

## Test plan
Bench parameters: POWER_W=3, MIN_POWER=2, CHARGE_STEP_CYCLES=4, HOLD_CYCLES=20, N_FRAMES=4, FRAME_CYCLES=8, LOCAL_PLAYER=0.
- Normal throw: turn=0, space low 1 cycle, then held 12 CHARGE cycles, then released → `power`=3; single `throw_start`; `throw_enable` high 20 cycles; `index` sequence 1, 2×8, 3×12, 3 (DONE), 0.
- Tap rejection: hold 5 cycles (`power`=1) then release → IDLE, `power`=0, no `throw_start`, `throw_enable` stays 0.
- Saturation: hold 60 cycles → `power` reaches 7 and stays 7; release → throw with `power`=7.
- Turn abort: turn switches to 1 at THROW cycle 5 → next cycle all outputs 0, OFF. Turn returns to 0 with space held → ARM, no CHARGE until space is low for one cycle.
- Simultaneous release and turn change (`power`=3) → no `throw_start`, OFF.
- Async reset: `rst_n` low mid-CHARGE between edges → all outputs 0 immediately. After release, turn=0 → ARM → IDLE.

Source files
------------

// File: rtl/throw_charge_fsm.sv
// Per-player charged-throw controller: press/hold/release on the space key becomes a
// power-latched launch strobe, a fixed-length throw window and a sprite frame index.
module throw_charge_fsm #(
    parameter int unsigned TURN_W             = 1,
    parameter int unsigned LOCAL_PLAYER       = 0,
    parameter int unsigned POWER_W            = 7,
    parameter int unsigned MIN_POWER          = 4,
    parameter int unsigned CHARGE_STEP_CYCLES = 650_000,
    parameter int unsigned HOLD_CYCLES        = 65_000_000,
    parameter int unsigned N_FRAMES           = 4,
    parameter int unsigned FRAME_CYCLES       = 16_250_000,
    localparam int unsigned IDX_W             = (N_FRAMES > 2) ? $clog2(N_FRAMES) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              space,
    input  logic [TURN_W-1:0] whose_turn,
    output logic [IDX_W-1:0]  index,
    output logic [POWER_W-1:0] power,
    output logic              throw_start,
    output logic              throw_enable,
    output logic              busy
);

    localparam int unsigned STEP_W  = (CHARGE_STEP_CYCLES > 1) ? $clog2(CHARGE_STEP_CYCLES) : 1;
    localparam int unsigned HOLD_W  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int unsigned FRAME_W = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;

    localparam logic [STEP_W-1:0]  STEP_LAST  = STEP_W'(CHARGE_STEP_CYCLES - 1);
    localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(FRAME_CYCLES - 1);
    localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(N_FRAMES - 1);

    typedef enum logic [2:0] {
        S_OFF,
        S_ARM,
        S_IDLE,
        S_CHARGE,
        S_THROW,
        S_DONE
    } state_t;

    state_t             state, state_n;
    logic [STEP_W-1:0]  step_cnt, step_cnt_n;
    logic [HOLD_W-1:0]  hold_cnt, hold_cnt_n;
    logic [FRAME_W-1:0] frame_cnt, frame_cnt_n;
    logic [POWER_W-1:0] power_n;
    logic [IDX_W-1:0]   index_n;
    logic               my_turn;

    assign my_turn = (whose_turn == TURN_W'(LOCAL_PLAYER));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_OFF;
            step_cnt  <= '0;
            hold_cnt  <= '0;
            frame_cnt <= '0;
            power     <= '0;
            index     <= '0;
        end else begin
            state     <= state_n;
            step_cnt  <= step_cnt_n;
            hold_cnt  <= hold_cnt_n;
            frame_cnt <= frame_cnt_n;
            power     <= power_n;
            index     <= index_n;
        end
    end

    always_comb begin
        state_n     = state;
        step_cnt_n  = step_cnt;
        hold_cnt_n  = hold_cnt;
        frame_cnt_n = frame_cnt;
        power_n     = power;
        index_n     = index;

        case (state)
            S_OFF: begin
                power_n = '0;
                index_n = '0;
                state_n = S_ARM;
            end
            S_ARM: begin
                if (!space) state_n = S_IDLE;
            end
            S_IDLE: begin
                if (space) begin
                    state_n    = S_CHARGE;
                    power_n    = '0;
                    step_cnt_n = '0;
                    index_n    = IDX_W'(1);
                end
            end
            S_CHARGE: begin
                if (space) begin
                    if (step_cnt == STEP_LAST) begin
                        step_cnt_n = '0;
                        if (power != '1) power_n = power + POWER_W'(1);
                    end else begin
                        step_cnt_n = step_cnt + STEP_W'(1);
                    end
                end else if (32'(power) >= MIN_POWER) begin
                    state_n     = S_THROW;
                    hold_cnt_n  = '0;
                    frame_cnt_n = '0;
                    index_n     = IDX_W'(2);
                end else begin
                    state_n = S_IDLE;
                    power_n = '0;
                    index_n = '0;
                end
            end
            S_THROW: begin
                hold_cnt_n = hold_cnt + HOLD_W'(1);
                if (frame_cnt == FRAME_LAST) begin
                    frame_cnt_n = '0;
                    if (index != IDX_LAST) index_n = index + IDX_W'(1);
                end else begin
                    frame_cnt_n = frame_cnt + FRAME_W'(1);
                end
                if (hold_cnt == HOLD_LAST) state_n = S_DONE;
            end
            S_DONE: begin
                state_n = space ? S_ARM : S_IDLE;
                power_n = '0;
                index_n = '0;
            end
            default: state_n = S_OFF;
        endcase

        // Losing the turn overrides every transition above, including a same-edge release.
        if (!my_turn) begin
            state_n     = S_OFF;
            step_cnt_n  = '0;
            hold_cnt_n  = '0;
            frame_cnt_n = '0;
            power_n     = '0;
            index_n     = '0;
        end
    end

    assign throw_start  = (state == S_THROW) && (hold_cnt == '0);
    assign throw_enable = (state == S_THROW);
    assign busy         = (state == S_CHARGE) || (state == S_THROW) || (state == S_DONE);

endmodule

// File: tb/tb_throw_charge_fsm.sv
// Randomised and directed bench for throw_charge_fsm against a timeline-arithmetic
// reference model (charge cycles, throw age and latched power).
module tb_throw_charge_fsm;

    localparam int PW    = 3;
    localparam int MINP  = 2;
    localparam int STEP  = 4;
    localparam int HOLD  = 20;
    localparam int NF    = 4;
    localparam int FRAME = 8;
    localparam int PMAX  = (1 << PW) - 1;

    localparam int M_OFF = 0, M_ARM = 1, M_IDLE = 2, M_CHARGE = 3, M_THROW = 4, M_DONE = 5;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         space;
    logic [0:0]   whose_turn;
    logic [1:0]   index;
    logic [PW-1:0] power;
    logic         throw_start;
    logic         throw_enable;
    logic         busy;

    int checks = 0;
    int errors = 0;

    int m_mode, m_k, m_age, m_lp;
    int exp_strobes = 0;
    int got_strobes = 0;

    throw_charge_fsm #(
        .TURN_W(1), .LOCAL_PLAYER(0), .POWER_W(PW), .MIN_POWER(MINP),
        .CHARGE_STEP_CYCLES(STEP), .HOLD_CYCLES(HOLD), .N_FRAMES(NF), .FRAME_CYCLES(FRAME)
    ) dut (
        .clk(clk), .rst_n(rst_n), .space(space), .whose_turn(whose_turn),
        .index(index), .power(power), .throw_start(throw_start),
        .throw_enable(throw_enable), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic model_reset();
        m_mode = M_OFF; m_k = 0; m_age = 0; m_lp = 0;
    endtask

    task automatic model_step(input bit s, input bit t);
        int p;
        if (t != 1'b0) begin
            model_reset();
            return;
        end
        case (m_mode)
            M_OFF:  m_mode = M_ARM;
            M_ARM:  if (!s) m_mode = M_IDLE;
            M_IDLE: if (s) begin m_mode = M_CHARGE; m_k = 0; end
            M_CHARGE: begin
                p = imin(m_k / STEP, PMAX);
                if (s) m_k++;
                else if (p >= MINP) begin
                    m_mode = M_THROW; m_lp = p; m_age = 0; exp_strobes++;
                end else m_mode = M_IDLE;
            end
            M_THROW: begin
                m_age++;
                if (m_age == HOLD) m_mode = M_DONE;
            end
            M_DONE: m_mode = s ? M_ARM : M_IDLE;
            default: m_mode = M_OFF;
        endcase
    endtask

    task automatic compare_all();
        int ep, ei;
        ep = 0; ei = 0;
        case (m_mode)
            M_CHARGE: begin ep = imin(m_k / STEP, PMAX); ei = 1; end
            M_THROW:  begin ep = m_lp; ei = imin(2 + m_age / FRAME, NF - 1); end
            M_DONE:   begin ep = m_lp; ei = imin(2 + (HOLD - 1) / FRAME, NF - 1); end
            default:  ;
        endcase
        check("power", int'(power), ep);
        check("index", int'(index), ei);
        check("throw_start", int'(throw_start), int'(m_mode == M_THROW && m_age == 0));
        check("throw_enable", int'(throw_enable), int'(m_mode == M_THROW));
        check("busy", int'(busy), int'(m_mode == M_CHARGE || m_mode == M_THROW || m_mode == M_DONE));
        if (throw_start) got_strobes++;
    endtask

    // Drive inputs just after a falling edge, let one rising edge pass, compare on the next fall.
    task automatic tick(input bit s, input bit t);
        space = s;
        whose_turn = t;
        @(posedge clk);
        model_step(s, t);
        @(negedge clk);
        compare_all();
    endtask

    task automatic ticks(input int n, input bit s, input bit t);
        for (int i = 0; i < n; i++) tick(s, t);
    endtask

    initial begin
        bit rs, rt;
        int len;
        rst_n = 1'b0;
        space = 1'b0;
        whose_turn = 1'b0;
        model_reset();
        #23;
        check("reset_power", int'(power), 0);
        check("reset_busy", int'(busy), 0);
        compare_all();
        @(negedge clk);
        rst_n = 1'b1;

        // Normal throw: OFF->ARM->IDLE, press, 12 held cycles, release.
        ticks(2, 1'b0, 1'b0);
        tick(1'b1, 1'b0);
        check("norm_idx_charge", int'(index), 1);
        ticks(12, 1'b1, 1'b0);
        check("norm_power_held", int'(power), 3);
        tick(1'b0, 1'b0);
        check("norm_strobe", int'(throw_start), 1);
        check("norm_power_latch", int'(power), 3);
        ticks(HOLD - 1, 1'b0, 1'b0);
        check("norm_enable_last", int'(throw_enable), 1);
        tick(1'b0, 1'b0);
        check("norm_done_idx", int'(index), 3);
        check("norm_done_enable", int'(throw_enable), 0);
        tick(1'b0, 1'b0);
        check("norm_idle_idx", int'(index), 0);

        // Tap rejection.
        tick(1'b1, 1'b0);
        ticks(5, 1'b1, 1'b0);
        check("tap_power", int'(power), 1);
        tick(1'b0, 1'b0);
        check("tap_no_strobe", int'(throw_start), 0);
        check("tap_busy", int'(busy), 0);

        // Saturation.
        tick(1'b1, 1'b0);
        ticks(60, 1'b1, 1'b0);
        check("sat_power", int'(power), 7);
        tick(1'b0, 1'b0);
        check("sat_strobe_power", int'(power), 7);
        ticks(HOLD + 1, 1'b0, 1'b0);

        // Turn abort during THROW, then re-entry with space held.
        tick(1'b1, 1'b0);
        ticks(12, 1'b1, 1'b0);
        tick(1'b0, 1'b0);
        ticks(4, 1'b0, 1'b0);
        tick(1'b0, 1'b1);
        check("abort_enable", int'(throw_enable), 0);
        check("abort_busy", int'(busy), 0);
        ticks(3, 1'b1, 1'b0);
        check("abort_arm_busy", int'(busy), 0);
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        check("abort_recharge", int'(busy), 1);

        // Release together with turn change.
        ticks(12, 1'b1, 1'b0);
        tick(1'b0, 1'b1);
        check("simul_strobe", int'(throw_start), 0);
        check("simul_busy", int'(busy), 0);

        // Asynchronous reset between edges mid-CHARGE.
        ticks(2, 1'b0, 1'b0);
        tick(1'b1, 1'b0);
        ticks(6, 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("areset_power", int'(power), 0);
        check("areset_index", int'(index), 0);
        compare_all();
        #1 rst_n = 1'b1;
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        check("areset_idle_busy", int'(busy), 0);

        // Random bursts.
        for (int b = 0; b < 120; b++) begin
            rs  = 1'($urandom_range(0, 1));
            rt  = ($urandom_range(0, 9) == 0);
            len = (rs && $urandom_range(0, 1) == 1) ? $urandom_range(6, 40) : $urandom_range(1, 25);
            ticks(len, rs, rt);
        end

        check("strobe_count", got_strobes, exp_strobes);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
